// File: rtl/slc3_mem_pkg.sv
// Shared types for the SLC-3 external SRAM path: FSM states, port owners,
// strobe bundle and the state-to-strobe decode used by sram_arbiter.
package slc3_mem_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} arb_state_t;
  typedef enum logic {PORT_CPU, PORT_DBG} arb_port_t;

  localparam int SRAM_DATA_W = 16;

  typedef struct packed {
    logic ce;
    logic oe;
    logic we;
    logic ub;
    logic lb;
  } sram_strobe_t;

  // Active-low strobe pattern for a state; a write drops OE/CE/UB/LB in DONE.
  function automatic sram_strobe_t decode_strobes(arb_state_t s, logic is_write);
    sram_strobe_t st;
    st = '1;
    case (s)
      SETUP: begin
        st.ce = 1'b0;
        st.ub = 1'b0;
        st.lb = 1'b0;
        st.oe = is_write;
      end
      ACCESS: begin
        st.ce = 1'b0;
        st.ub = 1'b0;
        st.lb = 1'b0;
        st.oe = is_write;
        st.we = ~is_write;
      end
      DONE: begin
        if (!is_write) begin
          st.ce = 1'b0;
          st.oe = 1'b0;
          st.ub = 1'b0;
          st.lb = 1'b0;
        end
      end
      default: st = '1;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sram_arb_select.sv
// Grant selection between the CPU and debug ports. Fixed CPU priority by
// default; defining SRAM_ARB_RR_EN adds a last-grant pointer for round-robin.
module sram_arb_select
  import slc3_mem_pkg::*;
(
  input  logic      Clk,
  input  logic      Reset,
  input  logic      take,
  input  logic      cpu_req,
  input  logic      dbg_req,
  output logic      grant_valid,
  output arb_port_t grant_port
);

  assign grant_valid = cpu_req | dbg_req;

`ifdef SRAM_ARB_RR_EN
  arb_port_t last_grant;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_grant <= PORT_DBG;
    end else if (take) begin
      last_grant <= grant_port;
    end
  end

  // On a tie the port that did not win last time goes first.
  always_comb begin
    grant_port = PORT_CPU;
    if (cpu_req && dbg_req) begin
      grant_port = (last_grant == PORT_CPU) ? PORT_DBG : PORT_CPU;
    end else if (dbg_req) begin
      grant_port = PORT_DBG;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = &{1'b0, Clk, Reset, take};

  always_comb begin
    grant_port = PORT_CPU;
    if (!cpu_req && dbg_req) begin
      grant_port = PORT_DBG;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// SLC-3 SRAM sequencer and two-port arbiter with registered, glitch-free
// strobes. Optional round-robin arbitration via macro SRAM_ARB_RR_EN.
module sram_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [SRAM_DATA_W-1:0] cpu_wdata,
  output logic [SRAM_DATA_W-1:0] cpu_rdata,
  output logic                   cpu_done,
  input  logic                   dbg_req,
  input  logic                   dbg_we,
  input  logic [ADDR_W-1:0]      dbg_addr,
  input  logic [SRAM_DATA_W-1:0] dbg_wdata,
  output logic [SRAM_DATA_W-1:0] dbg_rdata,
  output logic                   dbg_done,
  output logic                   busy,
  output logic                   CE,
  output logic                   OE,
  output logic                   WE,
  output logic                   UB,
  output logic                   LB,
  output logic [ADDR_W-1:0]      ADDR,
  output logic [SRAM_DATA_W-1:0] Data_Mem_Out,
  input  logic [SRAM_DATA_W-1:0] Data_Mem_In
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("sram_arbiter: WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  arb_state_t       state, next_state;
  logic [3:0]       cnt;
  arb_port_t        owner;
  logic             lat_we;
  sram_strobe_t     strobe_q;

  logic             grant_valid;
  arb_port_t        grant_port;
  logic             take;
  logic             sel_we;
  logic             next_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [SRAM_DATA_W-1:0] sel_wdata;

  assign take = (state == IDLE) && grant_valid;

  sram_arb_select u_select (
    .Clk         (Clk),
    .Reset       (Reset),
    .take        (take),
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  assign sel_we    = (grant_port == PORT_CPU) ? cpu_we    : dbg_we;
  assign sel_addr  = (grant_port == PORT_CPU) ? cpu_addr  : dbg_addr;
  assign sel_wdata = (grant_port == PORT_CPU) ? cpu_wdata : dbg_wdata;
  assign next_we   = take ? sel_we : lat_we;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_valid) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (cnt == 4'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes and done pulses are decoded from next_state so they change only on the clock edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      strobe_q     <= '1;
      cpu_done     <= 1'b0;
      dbg_done     <= 1'b0;
      cnt          <= 4'd0;
      owner        <= PORT_CPU;
      lat_we       <= 1'b0;
      ADDR         <= '0;
      Data_Mem_Out <= '0;
      cpu_rdata    <= '0;
      dbg_rdata    <= '0;
    end else begin
      strobe_q <= decode_strobes(next_state, next_we);
      cpu_done <= (next_state == DONE) && (owner == PORT_CPU);
      dbg_done <= (next_state == DONE) && (owner == PORT_DBG);
      if (take) begin
        owner        <= grant_port;
        lat_we       <= sel_we;
        ADDR         <= sel_addr;
        Data_Mem_Out <= sel_wdata;
      end
      if (state == SETUP) begin
        cnt <= CNT_LOAD;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ACCESS && cnt == 4'd0 && !lat_we) begin
        if (owner == PORT_CPU) cpu_rdata <= Data_Mem_In;
        else                   dbg_rdata <= Data_Mem_In;
      end
    end
  end

  assign busy = (state != IDLE);
  assign CE   = strobe_q.ce;
  assign OE   = strobe_q.oe;
  assign WE   = strobe_q.we;
  assign UB   = strobe_q.ub;
  assign LB   = strobe_q.lb;

endmodule
